// File: rtl/odo_pkg.sv
// Shared Odo definitions: small S-box width and the inverse-loader FSM state type.
package odo_pkg;

  localparam int ODO_SBOX_SMALL_W = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERROR = 2'd3
  } odo_sbox_inv_state_t;

endpackage

// File: rtl/odo_sbox_inv_ram.sv
// 2**W x W simple dual-port table: one write port, one registered read port.
// Only the read data register is reset; the array keeps stale contents.
module odo_sbox_inv_ram #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [W-1:0] raddr,
  output logic [W-1:0] rdata
);
  localparam int DEPTH = 2**W;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/odo_sbox_small_inv.sv
// Loadable inverse small S-box: streams fwd[i] in index order, stores inv[fwd[i]] = i,
// then serves registered lookups. Define ODO_SBOX_INV_CHECK_EN to enable duplicate detection.
module odo_sbox_small_inv
  import odo_pkg::*;
#(
  parameter int W       = ODO_SBOX_SMALL_W,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [W-1:0]        load_data,
  output logic                load_done,
  output logic                load_err,
  input  logic                lk_valid,
  input  logic [W-1:0]        lk_in,
  output logic                lk_out_valid,
  output logic [W-1:0]        lk_out,
  output odo_sbox_inv_state_t dbg_state
);
  localparam int         DEPTH = 2**W;
  localparam logic [W:0] LAST  = (W+1)'(DEPTH - 1);

  // Handshake: load_valid/load_data and lk_valid/lk_in are accepted on any cycle the
  // state allows (no ready, no backpressure); lk_out_valid qualifies lk_out for one cycle.

  odo_sbox_inv_state_t state;
  logic [W:0]          cnt;
  logic                dup;
  logic                wr_en;
  logic                rd_en;
  logic                rd_valid;
  logic [W-1:0]        rd_data;

`ifdef ODO_SBOX_INV_CHECK_EN
  logic [DEPTH-1:0] seen;
  logic             err_q;
  assign dup      = seen[load_data];
  assign load_err = err_q;
`else
  assign dup      = 1'b0;
  assign load_err = 1'b0;
`endif

  // load_start has priority over data in the same cycle, so its data is dropped.
  assign wr_en     = (state == LOAD) && load_valid && !load_start && !dup;
  // Reads only depend on READY, so a lookup alongside load_start uses the old table.
  assign rd_en     = (state == READY) && lk_valid;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      cnt       <= '0;
      load_done <= 1'b0;
`ifdef ODO_SBOX_INV_CHECK_EN
      seen      <= '0;
      err_q     <= 1'b0;
`endif
    end else if (load_start) begin
      state     <= LOAD;
      cnt       <= '0;
      load_done <= 1'b0;
`ifdef ODO_SBOX_INV_CHECK_EN
      seen      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            if (dup) begin
              state <= ERROR;
`ifdef ODO_SBOX_INV_CHECK_EN
              err_q <= 1'b1;
`endif
            end else begin
              cnt <= cnt + (W+1)'(1);
`ifdef ODO_SBOX_INV_CHECK_EN
              seen[load_data] <= 1'b1;
`endif
              if (cnt == LAST) begin
                state     <= READY;
                load_done <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  odo_sbox_inv_ram #(
    .W(W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(load_data),
    .wdata(cnt[W-1:0]),
    .re   (rd_en),
    .raddr(lk_in),
    .rdata(rd_data)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic         v_q;
      logic [W-1:0] d_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= rd_valid;
          if (rd_valid) begin
            d_q <= rd_data;
          end
        end
      end
      assign lk_out_valid = v_q;
      assign lk_out       = d_q;
    end else begin : g_no_out_reg
      assign lk_out_valid = rd_valid;
      assign lk_out       = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_odo_sbox_small_inv.sv
// Directed bench for odo_sbox_small_inv (W=6, OUT_REG=0); honours ODO_SBOX_INV_CHECK_EN.
module tb_odo_sbox_small_inv;
  import odo_pkg::*;

  logic                clk;
  logic                rst;
  logic                load_start;
  logic                load_valid;
  logic [5:0]          load_data;
  logic                load_done;
  logic                load_err;
  logic                lk_valid;
  logic [5:0]          lk_in;
  logic                lk_out_valid;
  logic [5:0]          lk_out;
  odo_sbox_inv_state_t dbg_state;

  int n_tests;
  int n_fail;

  logic [5:0] fwd   [64];
  logic [5:0] inv_m [64];

  odo_sbox_small_inv #(
    .W(6),
    .OUT_REG(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_err    (load_err),
    .lk_valid    (lk_valid),
    .lk_in       (lk_in),
    .lk_out_valid(lk_out_valid),
    .lk_out      (lk_out),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // small0-style table: fixed head and tail, remaining values in ascending order.
  task automatic build_table_a();
    int k;
    fwd[0]  = 6'h28;
    fwd[1]  = 6'h10;
    fwd[2]  = 6'h34;
    fwd[63] = 6'h2e;
    k = 3;
    for (int v = 0; v < 64; v++) begin
      if (v != 'h28 && v != 'h10 && v != 'h34 && v != 'h2e) begin
        fwd[k] = 6'(v);
        k++;
      end
    end
  endtask

  task automatic build_model();
    for (int i = 0; i < 64; i++) inv_m[fwd[i]] = 6'(i);
  endtask

  // Driver: load_start, then n entries of fwd with one idle gap; a lookup is
  // attempted at entry 20 and must be ignored.
  task automatic load_table(input int n, input int gap_at);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        load_valid = 1'b0;
        step();
      end
      load_valid = 1'b1;
      load_data  = fwd[i];
      lk_valid   = (i == 20);
      lk_in      = 6'h10;
      step();
      if (i == 21) chk("lookup_during_load", 32'(lk_out_valid), 32'd0);
      if (i == 62) chk("done_before_last", 32'(load_done), 32'd0);
    end
    load_valid = 1'b0;
    lk_valid   = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [5:0] a, input logic [5:0] exp);
    lk_valid = 1'b1;
    lk_in    = a;
    step();
    chk({tag, "_valid"}, 32'(lk_out_valid), 32'd1);
    chk(tag, 32'(lk_out), 32'(exp));
  endtask

  // Stimulus
  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    lk_valid   = 1'b0;
    lk_in      = '0;
    build_table_a();
    build_model();

    step();
    step();
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_lk_out_valid", 32'(lk_out_valid), 32'd0);
    chk("rst_lk_out", 32'(lk_out), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(EMPTY));
    rst = 1'b0;

    // Lookup while EMPTY is ignored
    lk_valid = 1'b1;
    lk_in    = 6'h10;
    step();
    lk_valid = 1'b0;
    chk("lookup_in_empty", 32'(lk_out_valid), 32'd0);
    chk("empty_state", 32'(dbg_state), 32'(EMPTY));

    // Load table A, first/last lookups
    load_table(64, 10);
    chk("load_done_a", 32'(load_done), 32'd1);
    chk("ready_state_a", 32'(dbg_state), 32'(READY));
    lookup("first_0x28", 6'h28, 6'h00);
    lookup("last_0x2e", 6'h2e, 6'h3f);
    lk_valid = 1'b0;
    step();
    chk("idle_valid", 32'(lk_out_valid), 32'd0);

    // Exhaustive back-to-back round-trip
    for (int a = 0; a < 64; a++) begin
      lookup("exhaustive", 6'(a), inv_m[a]);
    end

    // Restart from READY with a lookup in flight
    lk_valid   = 1'b1;
    lk_in      = 6'h10;
    load_start = 1'b1;
    step();
    lk_valid   = 1'b0;
    load_start = 1'b0;
    chk("restart_lk_valid", 32'(lk_out_valid), 32'd1);
    chk("restart_old_value", 32'(lk_out), 32'h01);
    chk("restart_done_fall", 32'(load_done), 32'd0);
    chk("restart_state", 32'(dbg_state), 32'(LOAD));
    step();
    chk("restart_no_extra", 32'(lk_out_valid), 32'd0);

    // Reload with table B = A ^ 0x15
    for (int i = 0; i < 64; i++) fwd[i] = fwd[i] ^ 6'h15;
    load_table(64, 40);
    chk("load_done_b", 32'(load_done), 32'd1);
    lookup("b_0x10", 6'h10, 6'h08);
    lookup("b_0x3d", 6'h3d, 6'h00);
    lookup("b_0x21", 6'h21, 6'h02);
    lk_valid = 1'b0;

    // Reset mid-load after 30 entries
    build_table_a();
    load_table(30, 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_load_done", 32'(load_done), 32'd0);
    chk("midrst_load_err", 32'(load_err), 32'd0);
    chk("midrst_lk_out_valid", 32'(lk_out_valid), 32'd0);
    chk("midrst_lk_out", 32'(lk_out), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(EMPTY));
    load_table(64, 63);
    chk("load_done_after_rst", 32'(load_done), 32'd1);
    lookup("after_rst_0x34", 6'h34, 6'h02);
    lookup("after_rst_0x10", 6'h10, 6'h01);
    lk_valid = 1'b0;

    // Duplicate: entry 5 repeats entry 0's value
    fwd[5] = 6'h28;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = fwd[i];
      step();
`ifdef ODO_SBOX_INV_CHECK_EN
      if (i == 4) chk("dup_err_before", 32'(load_err), 32'd0);
      if (i == 5) begin
        chk("dup_err", 32'(load_err), 32'd1);
        chk("dup_state", 32'(dbg_state), 32'(ERROR));
      end
`endif
    end
    load_valid = 1'b0;
`ifdef ODO_SBOX_INV_CHECK_EN
    chk("dup_done_low", 32'(load_done), 32'd0);
    chk("dup_err_held", 32'(load_err), 32'd1);
    lk_valid = 1'b1;
    lk_in    = 6'h28;
    step();
    lk_valid = 1'b0;
    chk("dup_lookup_ignored", 32'(lk_out_valid), 32'd0);
`else
    chk("dup_done_nocheck", 32'(load_done), 32'd1);
    chk("dup_err_nocheck", 32'(load_err), 32'd0);
    lookup("dup_overwrite_0x28", 6'h28, 6'h05);
    lk_valid = 1'b0;
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
